// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader and its benches.
package prog_loader_pkg;

  // Loader state encoding
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_HI  = 4'd1;
  localparam logic [3:0] ST_LEN_LO  = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_WRITE   = 4'd5;
  localparam logic [3:0] ST_CSUM    = 4'd6;
  localparam logic [3:0] ST_RUN     = 4'd7;
  localparam logic [3:0] ST_ERR     = 4'd8;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    LEN_HI  = ST_LEN_HI,
    LEN_LO  = ST_LEN_LO,
    DATA_HI = ST_DATA_HI,
    DATA_LO = ST_DATA_LO,
    WRITE   = ST_WRITE,
    CSUM    = ST_CSUM,
    RUN     = ST_RUN,
    ERR     = ST_ERR
  } state_t;

  // Image words are sent high byte first
  localparam int BYTES_PER_WORD = 2;

  // CPU opcode constants reused by benches to build images
  localparam logic [2:0] OP_END = 3'b111;

endpackage

// File: rtl/prog_loader_xor_csum.sv
// 8-bit running XOR checksum with synchronous clear and enable.
module xor_csum (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  // Accumulate each enabled byte; clear wins over enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    csum <= 8'h00;
    else if (clr) csum <= 8'h00;
    else if (en)  csum <= csum ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: holds the CPU in reset, streams an image into memory, checks the
// XOR checksum and releases the CPU only on a good image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  state_t      state, state_nx;
  logic        accept, start_ok, csum_en;
  logic [7:0]  len_hi, hi_byte, csum;
  logic [15:0] len, len_rx;

  assign accept   = rx_valid & rx_ready;
  // start only matters outside an active load
  assign start_ok = start && (state == IDLE || state == RUN || state == ERR);
  // The received CSUM byte itself is never folded into the sum
  assign csum_en  = accept && (state != CSUM);
  assign len_rx   = {len_hi, rx_data};

  xor_csum u_csum (
    .clock (clock),
    .reset (reset),
    .clr   (start_ok),
    .en    (csum_en),
    .din   (rx_data),
    .csum  (csum)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_rx == 16'd0)                 state_nx = CSUM;
          else if (len_rx > 16'(MAX_WORDS))    state_nx = ERR;
          else                                 state_nx = DATA_HI;
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (word_count + 16'd1 == len) state_nx = CSUM;
        else                           state_nx = DATA_HI;
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = (rx_data == csum) ? RUN : ERR;
      end
      RUN: begin
        // A restart re-holds the CPU in the very cycle start is seen
        cpu_reset = start;
        done      = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Length capture and word assembly from the byte stream
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi    <= 8'h00;
      len       <= 16'h0000;
      hi_byte   <= 8'h00;
      mem_wdata <= '0;
    end else begin
      if (start_ok) len <= 16'h0000;
      if (accept) begin
        case (state)
          LEN_HI:  len_hi    <= rx_data;
          LEN_LO:  len       <= len_rx;
          DATA_HI: hi_byte   <= rx_data;
          DATA_LO: mem_wdata <= DATA_WIDTH'({hi_byte, rx_data});
          default: ;
        endcase
      end
    end
  end

  // Address and word counters advance once per committed write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      word_count <= 16'h0000;
    end else if (start_ok) begin
      mem_addr   <= '0;
      word_count <= 16'h0000;
    end else if (state == WRITE) begin
      mem_addr   <= mem_addr + ADDR_WIDTH'(1);
      word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 256;

  logic          clock = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_we, cpu_reset, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [15:0]   word_count;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mem [0:(2**AW)-1];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next expected write, in order
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      wr_t e;
      check("rx_ready_in_write", 32'(rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
      mem[mem_addr] = mem_wdata;
    end
  end

  // Present one byte after a random idle gap and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, gap)) begin @(posedge clock); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      if (rx_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got no ready for byte %0h expected ready within 50 cycles", b);
    end
  endtask

  task automatic pulse_start(input bit check_hold);
    start = 1'b1;
    @(negedge clock);
    if (check_hold) check("cpu_reset_same_cycle_as_start", 32'(cpu_reset), 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Send a full image and check the final status against the format rules
  task automatic run_image(input string tag, input logic [15:0] n, input logic [15:0] words[$],
                           input bit bad, input int gap, input bit check_hold);
    logic [7:0] cs;
    bit         fin, exp_ok;
    int         exp_wc;
    wr_t        e;
    pulse_start(check_hold);
    cs = n[15:8] ^ n[7:0];
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    if (n > MW) begin
      exp_ok = 1'b0;
      exp_wc = 0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        e.addr = AW'(i);
        e.data = words[i];
        exp_q.push_back(e);
        for (int k = BYTES_PER_WORD - 1; k >= 0; k--) begin
          cs = cs ^ words[i][8*k +: 8];
          send_byte(words[i][8*k +: 8], gap);
        end
      end
      if (bad) cs = cs ^ 8'($urandom_range(1, 255));
      send_byte(cs, gap);
      exp_ok = !bad;
      exp_wc = int'(n);
    end
    fin = 1'b0;
    for (int t = 0; t < 20 && !fin; t++) begin
      @(negedge clock);
      if (done || error) fin = 1'b1;
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_end_timeout: got neither done nor error expected one within 20 cycles", tag);
    end
    check({tag, "_done"},       32'(done),       32'(exp_ok));
    check({tag, "_error"},      32'(error),      32'(!exp_ok));
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'(!exp_ok));
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] img1[$];
    logic [15:0] w[$];
    logic [15:0] none[$];
    logic [15:0] n;
    wr_t         e;

    img1 = '{16'h1234, 16'hABCD};
    none = {};
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    check_reset_values("por");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Good image: 00 02 12 34 AB CD 42
    run_image("good", 16'd2, img1, 1'b0, 0, 1'b0);
    check("good_mem0", 32'(mem[0]), 32'h1234);
    check("good_mem1", 32'(mem[1]), 32'hABCD);

    // Same image, wrong checksum; restart from RUN re-holds the CPU at once
    run_image("badcsum", 16'd2, img1, 1'b1, 0, 1'b1);
    check("badcsum_mem0", 32'(mem[0]), 32'h1234);
    check("badcsum_mem1", 32'(mem[1]), 32'hABCD);

    // Oversize length
    run_image("oversize", 16'(MW + 1), none, 1'b0, 0, 1'b0);

    // Empty image
    run_image("empty", 16'd0, none, 1'b0, 0, 1'b0);

    // Image 1 with random source gaps
    run_image("gaps", 16'd2, img1, 1'b0, 4, 1'b0);
    check("gaps_mem0", 32'(mem[0]), 32'h1234);
    check("gaps_mem1", 32'(mem[1]), 32'hABCD);

    // Random images, some with bad checksums
    for (int r = 0; r < 10; r++) begin
      n = 16'($urandom_range(1, 6));
      w = {};
      for (int i = 0; i < int'(n); i++)
        w.push_back(($urandom_range(0, 3) == 0) ? {OP_END, 13'($urandom)} : 16'($urandom));
      run_image("rand", n, w, ($urandom_range(0, 3) == 0), 3, (r % 2 == 0) && done);
    end

    // Largest accepted image
    w = {};
    for (int i = 0; i < MW; i++) w.push_back(16'($urandom));
    run_image("max", 16'(MW), w, 1'b0, 0, 1'b1);
    check("max_mem_last", 32'(mem[MW-1]), 32'(w[MW-1]));

    // Reset after three data bytes: only the first word is written
    pulse_start(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    e.addr = '0;
    e.data = 16'h1234;
    exp_q.push_back(e);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midreset");
    check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_image("reload", 16'd2, img1, 1'b0, 2, 1'b0);
    check("reload_mem0", 32'(mem[0]), 32'h1234);
    check("reload_mem1", 32'(mem[1]), 32'hABCD);
    run_image("restart", 16'd2, img1, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
